// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one ALU datapath between NUM_REQ requesters.
// Optional macro ALU_ARB_CMD_CHECK_EN: illegal commands are answered with an error and never issued.

module alu_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 8,
   parameter int CW      = 4,
   parameter int ALU_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*DW-1:0]      req_opa,
   input  logic [NUM_REQ*DW-1:0]      req_opb,
   input  logic [NUM_REQ*CW-1:0]      req_cmd,
   input  logic [NUM_REQ-1:0]         req_mode,
   input  logic [NUM_REQ-1:0]         req_cin,
   input  logic [NUM_REQ*2-1:0]       req_inp_valid,
   output logic                       alu_ce,
   output logic [DW-1:0]              alu_opa,
   output logic [DW-1:0]              alu_opb,
   output logic [CW-1:0]              alu_cmd,
   output logic                       alu_mode,
   output logic                       alu_cin,
   output logic [1:0]                 alu_inp_valid,
   input  logic [2*DW-1:0]            alu_res,
   input  logic                       alu_cout,
   input  logic                       alu_oflow,
   input  logic                       alu_g,
   input  logic                       alu_e,
   input  logic                       alu_l,
   input  logic                       alu_err,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [2*DW-1:0]            rsp_res,
   output logic                       rsp_cout,
   output logic                       rsp_oflow,
   output logic                       rsp_g,
   output logic                       rsp_e,
   output logic                       rsp_l,
   output logic                       rsp_err
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                 state_r;
   logic [IW-1:0]          ptr_r;
   logic [IW-1:0]          id_r;
   logic [1:0]             cnt_r;

   logic [2*NUM_REQ-1:0]   dbl_s;
   logic [NUM_REQ-1:0]     rot_s;
   int                     off_s;
   int                     sum_s;
   logic                   hit_s;
   logic [IW-1:0]          win_s;
   logic [NUM_REQ-1:0]     grant_s;
   logic                   legal_s;

   logic [DW-1:0]          win_opa_s;
   logic [DW-1:0]          win_opb_s;
   logic [CW-1:0]          win_cmd_s;
   logic                   win_mode_s;
   logic                   win_cin_s;
   logic [1:0]             win_inp_valid_s;

`ifdef ALU_ARB_CMD_CHECK_EN
   function automatic logic cmd_legal(input logic mode, input logic [CW-1:0] cmd);
      logic ok;
      if (mode) begin
         ok = (32'(cmd) <= 32'd10);
      end else begin
         ok = (32'(cmd) <= 32'd13);
      end
      return ok;
   endfunction
`endif

   // Rotate the request vector so ptr sits at bit 0; the lowest set bit is the winner.
   always_comb begin
      dbl_s = {req_valid, req_valid};
      rot_s = NUM_REQ'(dbl_s >> ptr_r);
      off_s = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         off_s = rot_s[k] ? k : off_s;
      end
      sum_s = int'(ptr_r) + off_s;
      win_s = (sum_s >= NUM_REQ) ? IW'(sum_s - NUM_REQ) : IW'(sum_s);
      hit_s = |req_valid;
   end

   // Select the winner's operation fields from the packed request buses.
   always_comb begin
      win_opa_s       = {DW{1'b0}};
      win_opb_s       = {DW{1'b0}};
      win_cmd_s       = {CW{1'b0}};
      win_mode_s      = 1'b0;
      win_cin_s       = 1'b0;
      win_inp_valid_s = 2'b00;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_opa_s       = (win_s == IW'(i)) ? req_opa[i*DW +: DW]     : win_opa_s;
         win_opb_s       = (win_s == IW'(i)) ? req_opb[i*DW +: DW]     : win_opb_s;
         win_cmd_s       = (win_s == IW'(i)) ? req_cmd[i*CW +: CW]     : win_cmd_s;
         win_mode_s      = (win_s == IW'(i)) ? req_mode[i]             : win_mode_s;
         win_cin_s       = (win_s == IW'(i)) ? req_cin[i]              : win_cin_s;
         win_inp_valid_s = (win_s == IW'(i)) ? req_inp_valid[i*2 +: 2] : win_inp_valid_s;
      end
   end

   // One-hot grant, only in IDLE; held low while reset is asserted.
   always_comb begin
      grant_s = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_s[i] = rst_n & hit_s & (state_r == IDLE) & (win_s == IW'(i));
      end
`ifdef ALU_ARB_CMD_CHECK_EN
      legal_s = cmd_legal(win_mode_s, win_cmd_s);
`else
      legal_s = 1'b1;
`endif
   end

   assign req_ready = grant_s;

   // Arbitration FSM with registered ALU drive and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         ptr_r         <= {IW{1'b0}};
         id_r          <= {IW{1'b0}};
         cnt_r         <= 2'd0;
         alu_ce        <= 1'b0;
         alu_opa       <= {DW{1'b0}};
         alu_opb       <= {DW{1'b0}};
         alu_cmd       <= {CW{1'b0}};
         alu_mode      <= 1'b0;
         alu_cin       <= 1'b0;
         alu_inp_valid <= 2'b00;
         rsp_valid     <= 1'b0;
         rsp_id        <= {IW{1'b0}};
         rsp_res       <= {(2*DW){1'b0}};
         rsp_cout      <= 1'b0;
         rsp_oflow     <= 1'b0;
         rsp_g         <= 1'b0;
         rsp_e         <= 1'b0;
         rsp_l         <= 1'b0;
         rsp_err       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (hit_s && legal_s) begin
                  id_r          <= win_s;
                  alu_opa       <= win_opa_s;
                  alu_opb       <= win_opb_s;
                  alu_cmd       <= win_cmd_s;
                  alu_mode      <= win_mode_s;
                  alu_cin       <= win_cin_s;
                  alu_inp_valid <= win_inp_valid_s;
                  alu_ce        <= 1'b1;
                  state_r       <= ISSUE;
               end else if (hit_s) begin
                  // Rejected command: answer straight away, ALU inputs untouched.
                  id_r      <= win_s;
                  rsp_valid <= 1'b1;
                  rsp_id    <= win_s;
                  rsp_res   <= {(2*DW){1'b0}};
                  rsp_cout  <= 1'b0;
                  rsp_oflow <= 1'b0;
                  rsp_g     <= 1'b0;
                  rsp_e     <= 1'b0;
                  rsp_l     <= 1'b0;
                  rsp_err   <= 1'b1;
                  state_r   <= RESP;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               alu_ce  <= 1'b0;
               cnt_r   <= 2'(ALU_LAT - 1);
               state_r <= WAIT;
            end
            WAIT: begin
               if (cnt_r == 2'd0) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id_r;
                  rsp_res   <= alu_res;
                  rsp_cout  <= alu_cout;
                  rsp_oflow <= alu_oflow;
                  rsp_g     <= alu_g;
                  rsp_e     <= alu_e;
                  rsp_l     <= alu_l;
                  rsp_err   <= alu_err;
                  state_r   <= RESP;
               end else begin
                  cnt_r <= cnt_r - 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr_r     <= (id_r == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : id_r + IW'(1);
                  state_r   <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               alu_ce    <= 1'b0;
               rsp_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
